// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and register
// field positions used by the register file and the request arbiter.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int SR_EXL       = 1;
  localparam int SR_IE        = 0;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;

  // EPC only ever holds word addresses.
  function automatic logic [31:0] word_align(input logic [31:0] v);
    return v & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/cp0_irq_arb.sv
// Combinational exception/interrupt arbiter: decides whether the M-stage
// instruction is taken and which ExcCode gets recorded.
module cp0_irq_arb
  import cp0_pkg::*;
(
  input  logic       ie,
  input  logic       exl,
  input  logic [5:0] im,
  input  logic [5:0] hw_int,
  input  logic [4:0] exc_code_in,
  output logic       req,
  output logic [4:0] exc_code
);

  logic int_req;
  logic exc_req;

  // Interrupts win over synchronous exceptions; EXL masks both.
  assign int_req  = ie & ~exl & (|(im & hw_int));
  assign exc_req  = ~exl & (exc_code_in != EXC_INT);
  assign req      = int_req | exc_req;
  assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) with exception entry,
// eret handling and an EPC forward path for the next-PC logic.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID     = 32'h2022_0007,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] pc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [4:0]  sel_exc;
  logic [31:0] pc_aligned;

  cp0_irq_arb u_arb (
    .ie          (sr_ie),
    .exl         (sr_exl),
    .im          (sr_im),
    .hw_int      (hw_int),
    .exc_code_in (exc_code_in),
    .req         (req),
    .exc_code    (sel_exc)
  );

  assign pc_aligned = word_align(pc);

  // A taken request flushes the M-stage instruction, so its mtc0 is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= IM_RESET;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= 6'b0;
      cause_exc <= 5'b0;
      epc       <= 32'b0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_in;
        cause_exc <= sel_exc;
        epc       <= bd_in ? pc_aligned - 32'd4 : pc_aligned;
      end else begin
        if (en && addr == REG_SR) begin
          sr_im  <= wdata[SR_IM_HI:SR_IM_LO];
          sr_exl <= wdata[SR_EXL];
          sr_ie  <= wdata[SR_IE];
        end
        if (en && addr == REG_EPC) begin
          epc <= word_align(wdata);
        end
        // eret overrides an mtc0 SR write for the EXL bit only.
        if (exl_clr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = 32'b0;
    case (addr)
      REG_SR: begin
        rdata[SR_IM_HI:SR_IM_LO] = sr_im;
        rdata[SR_EXL]            = sr_exl;
        rdata[SR_IE]             = sr_ie;
      end
      REG_CAUSE: begin
        rdata[CAUSE_BD]                  = cause_bd;
        rdata[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
        rdata[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
      end
      REG_EPC:  rdata = epc;
      REG_PRID: rdata = PRID;
      default:  rdata = 32'b0;
    endcase
  end

  // Forward a same-cycle mtc0 EPC so an immediately following eret sees it.
  assign epc_out = (en && addr == REG_EPC && !req) ? word_align(wdata) : epc;

endmodule

// File: tb/tb_cp0.sv
// Scenario testbench for cp0: expected register reads are queued as each
// scenario is driven and compared as the DUT is read back.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  typedef struct {
    string       name;
    logic [4:0]  raddr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  cp0 dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .pc          (pc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en          = 1'b0;
    addr        = 5'd0;
    wdata       = 32'h0;
    pc          = 32'h0;
    bd_in       = 1'b0;
    exc_code_in = 5'd0;
    exl_clr     = 1'b0;
  endtask

  function automatic void push_exp(string name, logic [4:0] a, logic [31:0] v);
    exp_t e;
    e.name  = name;
    e.raddr = a;
    e.val   = v;
    sb.push_back(e);
  endfunction

  task automatic test_reset();
    exp_t e;
    reset  = 1'b1;
    hw_int = 6'b0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    push_exp("reset_sr",    5'd12, 32'h0);
    push_exp("reset_cause", 5'd13, 32'h0);
    push_exp("reset_epc",   5'd14, 32'h0);
    push_exp("reset_prid",  5'd15, 32'h2022_0007);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    n_cmp++;
    if (req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_req: req=%b expected=0", req);
    end
    n_cmp++;
    if (epc_out !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_epc_out: epc_out=%h expected=00000000", epc_out);
    end
  endtask

  task automatic test_interrupt();
    exp_t e;
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_0401;
    tick();
    idle();
    hw_int = 6'b000001;
    pc     = 32'h0000_3010;
    bd_in  = 1'b0;
    #1;
    n_cmp++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL int_req: req=%b expected=1", req);
    end
    tick();
    idle();
    n_cmp++;
    if (req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL int_req_after_exl: req=%b expected=0", req);
    end
    push_exp("int_sr",    5'd12, 32'h0000_0403);
    push_exp("int_cause", 5'd13, 32'h0000_0400);
    push_exp("int_epc",   5'd14, 32'h0000_3010);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
  endtask

  task automatic test_exl_masked();
    exp_t e;
    exc_code_in = 5'd4;
    pc          = 32'h0000_5000;
    bd_in       = 1'b1;
    #1;
    n_cmp++;
    if (req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL exl_masks_exc: req=%b expected=0", req);
    end
    tick();
    idle();
    push_exp("masked_sr",    5'd12, 32'h0000_0403);
    push_exp("masked_cause", 5'd13, 32'h0000_0400);
    push_exp("masked_epc",   5'd14, 32'h0000_3010);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    exl_clr = 1'b1;
    hw_int  = 6'b0;
    tick();
    idle();
    push_exp("eret_sr",    5'd12, 32'h0000_0401);
    push_exp("eret_cause", 5'd13, 32'h0000_0000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
  endtask

  task automatic test_exception_bd();
    exp_t e;
    exc_code_in = 5'd12;
    pc          = 32'h0000_3020;
    bd_in       = 1'b1;
    #1;
    n_cmp++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ov_req: req=%b expected=1", req);
    end
    tick();
    idle();
    push_exp("ov_sr",    5'd12, 32'h0000_0403);
    push_exp("ov_cause", 5'd13, 32'h8000_0030);
    push_exp("ov_epc",   5'd14, 32'h0000_301C);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    exl_clr = 1'b1;
    tick();
    idle();
    push_exp("ov_eret_sr",    5'd12, 32'h0000_0401);
    push_exp("ov_eret_cause", 5'd13, 32'h8000_0030);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    hw_int      = 6'b000001;
    exc_code_in = 5'd10;
    pc          = 32'h0000_3040;
    bd_in       = 1'b0;
    en          = 1'b1;
    addr        = 5'd14;
    wdata       = 32'hFFFF_0000;
    #1;
    n_cmp++;
    if (req !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL prio_req: req=%b expected=1", req);
    end
    n_cmp++;
    if (epc_out !== 32'h0000_301C) begin
      n_fail++;
      $display("[TB] FAIL prio_epc_out_no_fwd: epc_out=%h expected=0000301c", epc_out);
    end
    tick();
    idle();
    hw_int = 6'b0;
    push_exp("prio_sr",    5'd12, 32'h0000_0403);
    push_exp("prio_cause", 5'd13, 32'h0000_0400);
    push_exp("prio_epc",   5'd14, 32'h0000_3040);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    exl_clr = 1'b1;
    tick();
    idle();
    push_exp("prio_eret_sr", 5'd12, 32'h0000_0401);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
  endtask

  task automatic test_epc_bypass();
    exp_t e;
    en    = 1'b1;
    addr  = 5'd14;
    wdata = 32'h0000_3007;
    #1;
    n_cmp++;
    if (epc_out !== 32'h0000_3004) begin
      n_fail++;
      $display("[TB] FAIL bypass_epc_out: epc_out=%h expected=00003004", epc_out);
    end
    n_cmp++;
    if (rdata !== 32'h0000_3040) begin
      n_fail++;
      $display("[TB] FAIL bypass_rdata_old: rdata=%h expected=00003040", rdata);
    end
    tick();
    idle();
    push_exp("bypass_epc_new", 5'd14, 32'h0000_3004);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    n_cmp++;
    if (epc_out !== 32'h0000_3004) begin
      n_fail++;
      $display("[TB] FAIL bypass_epc_out_reg: epc_out=%h expected=00003004", epc_out);
    end
  endtask

  task automatic test_writes_and_pulse();
    exp_t e;
    en = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    addr = 5'd15;
    tick();
    idle();
    hw_int = 6'b000010;
    #2;
    n_cmp++;
    if (req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL masked_int_req: req=%b expected=0", req);
    end
    hw_int = 6'b0;
    tick();
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03; exl_clr = 1'b1;
    tick();
    idle();
    push_exp("ro_cause",    5'd13, 32'h0000_0000);
    push_exp("ro_prid",     5'd15, 32'h2022_0007);
    push_exp("eret_wins",   5'd12, 32'h0000_FC01);
    push_exp("unmapped_rd", 5'd3,  32'h0000_0000);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
  endtask

  task automatic test_reset_in_exl();
    exp_t e;
    en = 1'b1; addr = 5'd12; wdata = 32'h0000_0003;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp("rst_exl_sr",    5'd12, 32'h0);
    push_exp("rst_exl_cause", 5'd13, 32'h0);
    push_exp("rst_exl_epc",   5'd14, 32'h0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      addr = e.raddr;
      #1;
      n_cmp++;
      if (rdata !== e.val) begin
        n_fail++;
        $display("[TB] FAIL %s: rdata=%h expected=%h", e.name, rdata, e.val);
      end
    end
    n_cmp++;
    if (req !== 1'b0 || epc_out !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL rst_exl_outputs: req=%b epc_out=%h expected req=0 epc_out=00000000", req, epc_out);
    end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_exl_masked();
    test_exception_bd();
    test_priority();
    test_epc_bypass();
    test_writes_and_pulse();
    test_reset_in_exl();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
